// File: rtl/fp_argext_stream.sv
// -----------------------------------------------------------------------------
// fp_argext_stream
//
// Streaming arg-max / arg-min over a vector of sign-magnitude floats with a
// configurable exponent/mantissa split. One element is consumed per accepted
// beat. The running best is compared combinationally against each incoming
// element, and the final beat's compare result is written straight into the
// output registers. The result is presented one cycle after the last beat and
// held until the consumer accepts it.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   mode_i         0 = arg-max, 1 = arg-min (taken from the first beat only)
//   in_valid_i     input element valid
//   in_ready_o     unit can accept an element (high while accumulating)
//   in_data_i      element {sign, exp, man}
//   in_last_i      element is the final one of its vector
//   out_valid_o    result valid (high while holding a result)
//   out_ready_i    consumer accepts the result
//   out_data_o     extreme element, bit-exact, or canonical qNaN if all NaN
//   out_idx_o      0-based (wrapped) position of the extreme element
//   out_nan_o      at least one element of the vector was NaN
//   out_all_nan_o  every element of the vector was NaN
//   out_ovf_o      the element counter wrapped before the last beat
// -----------------------------------------------------------------------------
module fp_argext_stream #(
  parameter int EXP_BITS  = 5,
  parameter int MAN_BITS  = 10,
  parameter int IDX_WIDTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               mode_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [1+EXP_BITS+MAN_BITS-1:0]     in_data_i,
  input  logic                               in_last_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [1+EXP_BITS+MAN_BITS-1:0]     out_data_o,
  output logic [IDX_WIDTH-1:0]               out_idx_o,
  output logic                               out_nan_o,
  output logic                               out_all_nan_o,
  output logic                               out_ovf_o
);

  localparam int WIDTH = 1 + EXP_BITS + MAN_BITS;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Strict "a > b" in sign-magnitude order for non-NaN operands. Both zeros
  // compare equal regardless of sign; infinities order by magnitude naturally.
  function automatic logic fp_gt(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-2:0] mag_a;
    logic [WIDTH-2:0] mag_b;
    logic             gt;
    mag_a = a[WIDTH-2:0];
    mag_b = b[WIDTH-2:0];
    if (mag_a == '0 && mag_b == '0) begin
      gt = 1'b0;
    end else if (a[WIDTH-1] != b[WIDTH-1]) begin
      gt = ~a[WIDTH-1];
    end else if (a[WIDTH-1]) begin
      gt = (mag_a < mag_b);
    end else begin
      gt = (mag_a > mag_b);
    end
    return gt;
  endfunction

  // State registers
  state_e                state_q,        state_d;
  logic [IDX_WIDTH-1:0]  cnt_q,          cnt_d;
  logic                  have_best_q,    have_best_d;
  logic [WIDTH-1:0]      best_q,         best_d;
  logic [IDX_WIDTH-1:0]  best_idx_q,     best_idx_d;
  logic                  nan_seen_q,     nan_seen_d;
  logic                  ovf_q,          ovf_d;
  logic                  mode_q,         mode_d;
  logic [WIDTH-1:0]      out_data_q,     out_data_d;
  logic [IDX_WIDTH-1:0]  out_idx_q,      out_idx_d;
  logic                  out_nan_q,      out_nan_d;
  logic                  out_all_nan_q,  out_all_nan_d;
  logic                  out_ovf_q,      out_ovf_d;

  // Per-beat combinational compare
  logic                  accept;
  logic                  first_beat;
  logic                  mode_eff;
  logic                  is_nan;
  logic                  take;
  logic [WIDTH-1:0]      new_best;
  logic [IDX_WIDTH-1:0]  new_idx;
  logic                  new_have;
  logic                  new_nan;

  assign in_ready_o = (state_q == ACCUM);
  assign accept     = in_valid_i && in_ready_o;

  // A zero counter after a wrap is not a first beat, hence the ovf_q term.
  assign first_beat = (cnt_q == '0) && !ovf_q;
  assign mode_eff   = first_beat ? mode_i : mode_q;

  assign is_nan = (&in_data_i[WIDTH-2 -: EXP_BITS]) &&
                  (in_data_i[MAN_BITS-1:0] != '0);

  assign take = !is_nan &&
                (!have_best_q ||
                 (mode_eff ? fp_gt(best_q, in_data_i) : fp_gt(in_data_i, best_q)));

  assign new_best = take ? in_data_i : best_q;
  assign new_idx  = take ? cnt_q     : best_idx_q;
  assign new_have = have_best_q | !is_nan;
  assign new_nan  = nan_seen_q  | is_nan;

  // NOTE: every signal assigned here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    have_best_d   = have_best_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    nan_seen_d    = nan_seen_q;
    ovf_d         = ovf_q;
    mode_d        = mode_q;
    out_data_d    = out_data_q;
    out_idx_d     = out_idx_q;
    out_nan_d     = out_nan_q;
    out_all_nan_d = out_all_nan_q;
    out_ovf_d     = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_last_i) begin
            // Final compare lands directly in the output registers; the
            // accumulator is cleared so the next vector starts fresh.
            out_data_d    = new_have ? new_best : QNAN;
            out_idx_d     = new_have ? new_idx  : '0;
            out_nan_d     = new_nan;
            out_all_nan_d = !new_have;
            out_ovf_d     = ovf_q;
            cnt_d         = '0;
            have_best_d   = 1'b0;
            nan_seen_d    = 1'b0;
            ovf_d         = 1'b0;
            state_d       = HOLD;
          end else begin
            best_d      = new_best;
            best_idx_d  = new_idx;
            have_best_d = new_have;
            nan_seen_d  = new_nan;
            mode_d      = mode_eff;
            cnt_d       = cnt_q + IDX_WIDTH'(1);
            // Counter rolls over on this beat and more elements follow.
            ovf_d       = ovf_q | (&cnt_q);
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d     = ACCUM;
          cnt_d       = '0;
          have_best_d = 1'b0;
          nan_seen_d  = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ACCUM;
      cnt_q         <= '0;
      have_best_q   <= 1'b0;
      best_q        <= '0;
      best_idx_q    <= '0;
      nan_seen_q    <= 1'b0;
      ovf_q         <= 1'b0;
      mode_q        <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      out_nan_q     <= 1'b0;
      out_all_nan_q <= 1'b0;
      out_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      have_best_q   <= have_best_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      nan_seen_q    <= nan_seen_d;
      ovf_q         <= ovf_d;
      mode_q        <= mode_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      out_nan_q     <= out_nan_d;
      out_all_nan_q <= out_all_nan_d;
      out_ovf_q     <= out_ovf_d;
    end
  end

  assign out_valid_o   = (state_q == HOLD);
  assign out_data_o    = out_data_q;
  assign out_idx_o     = out_idx_q;
  assign out_nan_o     = out_nan_q;
  assign out_all_nan_o = out_all_nan_q;
  assign out_ovf_o     = out_ovf_q;

endmodule

// File: tb/tb_fp_argext_stream.sv
// -----------------------------------------------------------------------------
// tb_fp_argext_stream
//
// Drives two fp16 instances of fp_argext_stream from the same stimulus: one
// with the default 8-bit index and one with a 2-bit index so that short
// vectors exercise the index wrap. Results are compared against a reference
// model that orders elements as signed integers (sign-magnitude value, zeros
// folded together), skipping NaNs.
// -----------------------------------------------------------------------------
module tb_fp_argext_stream;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a,  in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [15:0] out_data_a,  out_data_b;
  logic [7:0]  out_idx_a;
  logic [1:0]  out_idx_b;
  logic        out_nan_a,   out_nan_b;
  logic        out_all_a,   out_all_b;
  logic        out_ovf_a,   out_ovf_b;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [15:0] vec[$];
  bit          vmodes[$];
  bit          vmode;

  typedef struct {
    logic [15:0] data;
    int          idx;
    bit          nan;
    bit          all_nan;
    bit          ovf;
  } exp_t;

  fp_argext_stream #(.EXP_BITS(5), .MAN_BITS(10), .IDX_WIDTH(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_data_o(out_data_a), .out_idx_o(out_idx_a),
    .out_nan_o(out_nan_a), .out_all_nan_o(out_all_a), .out_ovf_o(out_ovf_a)
  );

  fp_argext_stream #(.EXP_BITS(5), .MAN_BITS(10), .IDX_WIDTH(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_data_o(out_data_b), .out_idx_o(out_idx_b),
    .out_nan_o(out_nan_b), .out_all_nan_o(out_all_b), .out_ovf_o(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the vector's mode is the one given with its first element.
  function automatic exp_t model(input int w);
    exp_t        r;
    bit          have;
    int          best_v;
    int          v;
    logic [15:0] e;
    have      = 1'b0;
    best_v    = 0;
    r.data    = 16'h0;
    r.idx     = 0;
    r.nan     = 1'b0;
    foreach (vec[i]) begin
      e = vec[i];
      if (e[14:10] == 5'h1f && e[9:0] != 10'h0) begin
        r.nan = 1'b1;
      end else begin
        v = int'(e[14:0]);
        if (e[15]) v = -v;
        if (!have || (vmode ? (v < best_v) : (v > best_v))) begin
          have   = 1'b1;
          best_v = v;
          r.data = e;
          r.idx  = i % (1 << w);
        end
      end
    end
    if (!have) begin
      r.data = 16'h7E00;
      r.idx  = 0;
    end
    r.all_nan = !have;
    r.ovf     = (vec.size() > (1 << w));
    return r;
  endfunction

  task automatic set_modes(input bit m);
    vmodes = {};
    foreach (vec[i]) vmodes.push_back(m);
    vmode = m;
  endtask

  // Sends vec (per-beat mode from vmodes), checks the result of both DUTs,
  // holds out_ready low for `hold` cycles, then completes the handshake.
  task automatic run_vec(input string tag, input int hold, input bit gaps,
                         input bit use_exp, input logic [15:0] x_data,
                         input int x_idx, input bit x_nan, input bit x_all,
                         input int x_idx_b, input bit x_ovf_b);
    exp_t        ea;
    exp_t        eb;
    logic [15:0] d0;
    int          n;
    ea = model(8);
    eb = model(2);
    foreach (vec[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = (i == vec.size() - 1);
      mode     = vmodes[i];
      n = 0;
      while (!in_ready_a && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready_a) check({tag, ".ready_timeout"}, 32'(in_ready_a), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    check({tag, ".lat_a"},  32'(out_valid_a), 32'd1);
    check({tag, ".lat_b"},  32'(out_valid_b), 32'd1);
    check({tag, ".data_a"}, 32'(out_data_a),  32'(ea.data));
    check({tag, ".idx_a"},  32'(out_idx_a),   32'(ea.idx));
    check({tag, ".nan_a"},  32'(out_nan_a),   32'(ea.nan));
    check({tag, ".all_a"},  32'(out_all_a),   32'(ea.all_nan));
    check({tag, ".ovf_a"},  32'(out_ovf_a),   32'(ea.ovf));
    check({tag, ".data_b"}, 32'(out_data_b),  32'(eb.data));
    check({tag, ".idx_b"},  32'(out_idx_b),   32'(eb.idx));
    check({tag, ".ovf_b"},  32'(out_ovf_b),   32'(eb.ovf));
    if (use_exp) begin
      check({tag, ".xdata"},  32'(out_data_a), 32'(x_data));
      check({tag, ".xidx"},   32'(out_idx_a),  32'(x_idx));
      check({tag, ".xnan"},   32'(out_nan_a),  32'(x_nan));
      check({tag, ".xall"},   32'(out_all_a),  32'(x_all));
      check({tag, ".xidx_b"}, 32'(out_idx_b),  32'(x_idx_b));
      check({tag, ".xovf_b"}, 32'(out_ovf_b),  32'(x_ovf_b));
    end

    d0 = out_data_a;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(out_valid_a), 32'd1);
      check({tag, ".hold_data"},  32'(out_data_a),  32'(d0));
      check({tag, ".hold_ready"}, 32'(in_ready_a),  32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid_a), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready_a),  32'd1);
  endtask

  function automatic logic [15:0] rand_elem();
    logic [15:0] specials [8];
    logic [15:0] pool     [6];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                 16'h7E00, 16'hFD01, 16'h0001, 16'h83FF};
    pool     = '{16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h0000, 16'h8000};
    case ($urandom_range(0, 5))
      0, 1:    return 16'($urandom);
      2:       return specials[$urandom_range(0, 7)];
      default: return pool[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst.valid", 32'(out_valid_a), 32'd0);
    check("rst.data",  32'(out_data_a),  32'd0);
    check("rst.idx",   32'(out_idx_a),   32'd0);
    check("rst.flags", {29'd0, out_nan_a, out_all_a, out_ovf_a}, 32'd0);
    check("rst.ready", 32'(in_ready_a),  32'd1);

    // Max with backpressure of 3 cycles.
    vec = '{16'h3C00, 16'hC000, 16'h4000}; set_modes(1'b0);
    run_vec("max", 3, 1'b0, 1'b1, 16'h4000, 2, 1'b0, 1'b0, 2, 1'b0);

    // Min, with mode_i flipped mid-vector (must be ignored).
    vec = '{16'h3C00, 16'hC000, 16'h4000}; set_modes(1'b1);
    vmodes[1] = 1'b0;
    vmodes[2] = 1'b0;
    run_vec("min", 0, 1'b0, 1'b1, 16'hC000, 1, 1'b0, 1'b0, 1, 1'b0);

    vec = '{16'h8000, 16'h0000}; set_modes(1'b0);
    run_vec("zero_tie", 1, 1'b0, 1'b1, 16'h8000, 0, 1'b0, 1'b0, 0, 1'b0);

    vec = '{16'h7BFF, 16'h7C00}; set_modes(1'b0);
    run_vec("inf", 0, 1'b0, 1'b1, 16'h7C00, 1, 1'b0, 1'b0, 1, 1'b0);

    vec = '{16'h0001, 16'h0000}; set_modes(1'b1);
    run_vec("denorm_min", 0, 1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1, 1'b0);

    vec = '{16'h7E00, 16'h3C00}; set_modes(1'b0);
    run_vec("nan_skip", 0, 1'b0, 1'b1, 16'h3C00, 1, 1'b1, 1'b0, 1, 1'b0);

    vec = '{16'hFD01}; set_modes(1'b0);
    run_vec("all_nan", 2, 1'b0, 1'b1, 16'h7E00, 0, 1'b1, 1'b1, 0, 1'b0);

    vec = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000}; set_modes(1'b0);
    run_vec("ovf", 0, 1'b0, 1'b1, 16'h4000, 4, 1'b0, 1'b0, 0, 1'b1);

    // Reset mid-vector discards the partial result.
    in_valid = 1'b1; in_last = 1'b0; mode = 1'b0;
    in_data  = 16'h7BFF; @(posedge clk); #1;
    in_data  = 16'h7C00; @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rst_mid.valid", 32'(out_valid_a), 32'd0);
    check("rst_mid.ready", 32'(in_ready_a),  32'd1);
    vec = '{16'h3C00}; set_modes(1'b0);
    run_vec("rst_mid", 0, 1'b0, 1'b1, 16'h3C00, 0, 1'b0, 1'b0, 0, 1'b0);

    // Reset while holding a result drops it.
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'h4400;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("rst_hold.pre", 32'(out_valid_a), 32'd1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rst_hold.valid", 32'(out_valid_a), 32'd0);
    check("rst_hold.data",  32'(out_data_a),  32'd0);

    // Randomized vectors.
    for (int t = 0; t < 60; t++) begin
      int len;
      len = $urandom_range(1, 9);
      vec = {};
      for (int j = 0; j < len; j++) vec.push_back(rand_elem());
      set_modes(1'($urandom_range(0, 1)));
      for (int j = 1; j < len; j++) vmodes[j] = 1'($urandom_range(0, 1));
      run_vec($sformatf("rnd%0d", t), $urandom_range(0, 3), 1'b1,
              1'b0, 16'h0, 0, 1'b0, 1'b0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fp_argext_stream.md
Name: fp_argext_stream

Overview:
- Streaming arg-max/arg-min unit over a vector of IEEE-style floats, parametrised in exponent/mantissa width.
- Consumes one element per beat with valid/ready and last. Returns the extreme value, its index and NaN flags one cycle after the last beat.
- Sits behind score/activation datapaths in the pipe_stage_timing group; successor of the fixed fp16 single-compare block. Adds min/max mode, NaN handling, ±0 equality, streaming and backpressure.

Parameters:
- EXP_BITS, 5, exponent field width
- MAN_BITS, 10, mantissa field width
- WIDTH, 1+EXP_BITS+MAN_BITS, element width (derived, localparam)
- IDX_WIDTH, 8, element index width; max vector length 2^IDX_WIDTH

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- mode_i  in  1  0 = arg-max, 1 = arg-min; sampled on first beat of each vector
- in_valid_i  in  1  input element valid
- in_ready_o  out  1  unit can accept element
- in_data_i  in  WIDTH  element {sign, exp, man}
- in_last_i  in  1  final element of vector
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- out_data_o  out  WIDTH  extreme element (bit-exact copy of input)
- out_idx_o  out  IDX_WIDTH  position of extreme element in vector (0-based)
- out_nan_o  out  1  at least one NaN element in vector
- out_all_nan_o  out  1  every element was NaN
- out_ovf_o  out  1  vector longer than 2^IDX_WIDTH elements

Behaviour:
- Reset (sync, rst_i=1 at edge): state ACCUM; out_valid_o=0; out_data_o=0; out_idx_o=0; all flags 0; element counter=0; have_best=0. Reset mid-vector or mid-HOLD discards all partial or pending results.
- Beat accepted when in_valid_i && in_ready_o.
- in_ready_o = 1 in ACCUM, 0 in HOLD. It is a registered-state decode only, with no combinational path from out_ready_i.
- States:
  - ACCUM: accepting elements. An accepted beat with in_last_i=1 writes the final result into the output registers and moves to HOLD.
  - HOLD: out_valid_o=1 and outputs stable. On out_ready_i=1, go to ACCUM next cycle with counter/have_best/flags cleared.
- Latency: last beat accepted in cycle N gives out_valid_o=1 in cycle N+1. The next vector's first beat is accepted no earlier than the cycle after the output handshake.
- Mode is latched from the first accepted beat (counter==0). mode_i changes mid-vector are ignored.
- Classification (per element):
  - NaN: exp all-ones and man≠0.
  - ±Inf: exp all-ones and man=0, ordered normally.
  - Denormals: ordered by magnitude, no flushing.
- Ordering: sign-magnitude total order on non-NaN values; +0 and -0 compare equal.
- Update rule:
  - NaN elements are never selected; they set nan_seen.
  - If have_best=0, a non-NaN element is taken unconditionally.
  - Otherwise it replaces best only if strictly greater (max) or strictly less (min).
  - Ties keep the earlier index.
- The compare is combinational against the best registers. The last beat's compare feeds the output registers directly, with no extra cycle.
- Index: element counter starts at 0 and increments per accepted beat. It wraps modulo 2^IDX_WIDTH; a wrap before last sets ovf, and the reported index is then the wrapped value.
- All-NaN vector: out_data_o = canonical quiet NaN (sign 0, exp all-ones, man MSB 1, rest 0); out_idx_o=0; out_nan_o=1; out_all_nan_o=1.
- out_valid_o and out payload stay stable while out_ready_i=0. No output drop or overwrite.

Test Plan:
- Max, fp16 stream 0x3C00, 0xC000, 0x4000(last) → out 0x4000, idx 2, nan=0, out_valid_o exactly 1 cycle after last beat.
- Same stream with mode_i=1 → out 0xC000, idx 1. Also toggle mode_i to 0 on beat 2 → result unchanged.
- Ties/zero/Inf, max mode:
  - 0x8000, 0x0000(last) → 0x8000, idx 0.
  - 0x7BFF, 0x7C00(last) → 0x7C00, idx 1.
  - Min mode 0x0001, 0x0000(last) → 0x0000, idx 1.
- NaN handling:
  - 0x7E00, 0x3C00(last) → 0x3C00, idx 1, nan=1, all_nan=0.
  - Single-beat 0xFD01(last) → 0x7E00, idx 0, nan=1, all_nan=1.
- Backpressure: hold out_ready_i=0 for 3 cycles after result → outputs stable, in_ready_o=0 throughout. Handshake, then next vector's first beat accepted the following cycle.
- Reset and overflow:
  - Assert rst_i after 2 beats, then send 0x3C00(last) → out 0x3C00, idx 0.
  - With IDX_WIDTH=2, send a 5-beat vector with max at beat 4 → idx 0, ovf=1.
